// File: rtl/ldr_sdram_sink_pkg.sv
// Shared types and constants for the loader-to-SDRAM byte sink.
// Optional checksum feature of the top is enabled with LDR_SDRAM_SINK_CKSUM_EN.
package ldr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECIDE,
    FLUSH,
    WRITE,
    ACKH,
    EOF
  } ldr_state_t;

  localparam logic [1:0] BE_LO = 2'b01;
  localparam logic [1:0] BE_HI = 2'b10;
  localparam logic [1:0] BE_W  = 2'b11;

  localparam int LDR_AW_DEF = 20;
  localparam int MEM_AW_DEF = 24;

endpackage

// File: rtl/ldr_sdram_sink_mem_wport.sv
// Single-outstanding write port: latches one word write on start_i, holds
// req/addr/wdat/be stable until the controller acks, then pulses done_o.
module ldr_mem_wport
  import ldr_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [MEM_AW-1:0] addr_i,
  input  logic [15:0]       wdat_i,
  input  logic [1:0]        be_i,
  input  logic              mem_ack_i,
  output logic              mem_req_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [15:0]       mem_wdat_o,
  output logic [1:0]        mem_be_o,
  output logic              done_o
);

  logic              req_q;
  logic [MEM_AW-1:0] addr_q;
  logic [15:0]       wdat_q;
  logic [1:0]        be_q;
  logic              done_q;

  // An ack seen while no request is pending is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      wdat_q <= '0;
      be_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (req_q) begin
        if (mem_ack_i) begin
          req_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end else if (start_i) begin
        req_q  <= 1'b1;
        addr_q <= addr_i;
        wdat_q <= wdat_i;
        be_q   <= be_i;
      end
    end
  end

  assign mem_req_o  = req_q;
  assign mem_addr_o = addr_q;
  assign mem_wdat_o = wdat_q;
  assign mem_be_o   = be_q;
  assign done_o     = done_q;

endmodule

// File: rtl/ldr_sdram_sink.sv
// Loader handshake responder that packs bytes into little-endian 16-bit SDRAM writes.
// Define LDR_SDRAM_SINK_CKSUM_EN to add the cksum / cksum_valid outputs.
module ldr_sdram_sink
  import ldr_pkg::*;
#(
  parameter int                LDR_AW   = LDR_AW_DEF,
  parameter int                MEM_AW   = MEM_AW_DEF,
  parameter logic [MEM_AW-1:0] MEM_BASE = '0
) (
  input  logic              cpuclk,
  input  logic              rstn,
  input  logic              LDR_OE,
  input  logic [LDR_AW-1:0] LDR_ADDR,
  input  logic [7:0]        LDR_WDAT,
  input  logic              LDR_WR,
  output logic              LDR_ACK,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdat,
  output logic [1:0]        mem_be,
  input  logic              mem_ack,
`ifdef LDR_SDRAM_SINK_CKSUM_EN
  output logic [15:0]       cksum,
  output logic              cksum_valid,
`endif
  output logic              busy
);

  ldr_state_t        state_q;
  logic              ack_q;
  logic              oe_q;
  logic              eof_pend_q;
  logic              hold_v_q;
  logic [LDR_AW-2:0] hold_waddr_q;
  logic [7:0]        hold_byte_q;
  logic [LDR_AW-1:0] lat_addr_q;
  logic [7:0]        lat_dat_q;
  logic              start_q;
  logic [1:0]        wp_be_q;

  logic [LDR_AW-2:0] lat_waddr;
  logic              same_word;
  logic              oe_rise;
  logic              oe_fall;
  logic              wp_done;
  logic [MEM_AW-1:0] wp_addr_d;
  logic [15:0]       wp_wdat_d;

`ifdef LDR_SDRAM_SINK_CKSUM_EN
  logic [15:0] cksum_q;
  logic        cksum_valid_q;
`endif

  function automatic logic [MEM_AW-1:0] to_mem(input logic [LDR_AW-2:0] waddr);
    return MEM_BASE + MEM_AW'(waddr);
  endfunction

  assign lat_waddr = lat_addr_q[LDR_AW-1:1];
  assign same_word = hold_v_q && (hold_waddr_q == lat_waddr);
  assign oe_rise   = LDR_OE && !oe_q;
  assign oe_fall   = !LDR_OE && oe_q;

  // The byte-enable kind selects the payload: a flush sends the held even byte,
  // the others carry the latched byte. Hold registers stay intact until the port latches.
  always_comb begin
    wp_addr_d = to_mem(lat_waddr);
    wp_wdat_d = {lat_dat_q, 8'h00};
    case (wp_be_q)
      BE_LO:   begin
        wp_addr_d = to_mem(hold_waddr_q);
        wp_wdat_d = {8'h00, hold_byte_q};
      end
      BE_W:    wp_wdat_d = {lat_dat_q, hold_byte_q};
      default: wp_wdat_d = {lat_dat_q, 8'h00};
    endcase
  end

  always_ff @(posedge cpuclk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      ack_q        <= 1'b0;
      oe_q         <= 1'b0;
      eof_pend_q   <= 1'b0;
      hold_v_q     <= 1'b0;
      hold_waddr_q <= '0;
      hold_byte_q  <= '0;
      lat_addr_q   <= '0;
      lat_dat_q    <= '0;
      start_q      <= 1'b0;
      wp_be_q      <= '0;
`ifdef LDR_SDRAM_SINK_CKSUM_EN
      cksum_q       <= '0;
      cksum_valid_q <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      oe_q    <= LDR_OE;
`ifdef LDR_SDRAM_SINK_CKSUM_EN
      cksum_valid_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (LDR_WR && LDR_OE) begin
            lat_addr_q <= LDR_ADDR;
            lat_dat_q  <= LDR_WDAT;
            state_q    <= DECIDE;
          end else if (eof_pend_q) begin
            eof_pend_q <= 1'b0;
            if (hold_v_q) begin
              wp_be_q <= BE_LO;
              start_q <= 1'b1;
              state_q <= EOF;
            end else begin
`ifdef LDR_SDRAM_SINK_CKSUM_EN
              cksum_valid_q <= 1'b1;
`endif
            end
          end
        end
        DECIDE: begin
          if (!lat_addr_q[0]) begin
            if (hold_v_q && !same_word) begin
              wp_be_q <= BE_LO;
              start_q <= 1'b1;
              state_q <= FLUSH;
            end else begin
              hold_v_q     <= 1'b1;
              hold_waddr_q <= lat_waddr;
              hold_byte_q  <= lat_dat_q;
              state_q      <= ACKH;
            end
          end else if (same_word) begin
            wp_be_q  <= BE_W;
            start_q  <= 1'b1;
            hold_v_q <= 1'b0;
            state_q  <= WRITE;
          end else if (hold_v_q) begin
            wp_be_q <= BE_LO;
            start_q <= 1'b1;
            state_q <= FLUSH;
          end else begin
            wp_be_q <= BE_HI;
            start_q <= 1'b1;
            state_q <= WRITE;
          end
        end
        // Once the stale even byte is out, finish absorbing the latched byte.
        FLUSH: begin
          if (wp_done) begin
            hold_v_q <= 1'b0;
            if (!lat_addr_q[0]) begin
              hold_v_q     <= 1'b1;
              hold_waddr_q <= lat_waddr;
              hold_byte_q  <= lat_dat_q;
              state_q      <= ACKH;
            end else begin
              wp_be_q <= BE_HI;
              start_q <= 1'b1;
              state_q <= WRITE;
            end
          end
        end
        WRITE: begin
          if (wp_done) state_q <= ACKH;
        end
        ACKH: begin
          if (!ack_q) begin
            ack_q <= 1'b1;
`ifdef LDR_SDRAM_SINK_CKSUM_EN
            cksum_q <= cksum_q + {8'h00, lat_dat_q};
`endif
          end else if (!LDR_WR) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        EOF: begin
          if (wp_done) begin
            hold_v_q <= 1'b0;
`ifdef LDR_SDRAM_SINK_CKSUM_EN
            cksum_valid_q <= 1'b1;
`endif
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Window edges override whatever the state machine did this cycle.
      if (oe_fall) eof_pend_q <= 1'b1;
      if (oe_rise) begin
        hold_v_q   <= 1'b0;
        eof_pend_q <= 1'b0;
`ifdef LDR_SDRAM_SINK_CKSUM_EN
        cksum_q    <= '0;
`endif
      end
    end
  end

  ldr_mem_wport #(
    .MEM_AW(MEM_AW)
  ) u_wport (
    .clk       (cpuclk),
    .rst_n     (rstn),
    .start_i   (start_q),
    .addr_i    (wp_addr_d),
    .wdat_i    (wp_wdat_d),
    .be_i      (wp_be_q),
    .mem_ack_i (mem_ack),
    .mem_req_o (mem_req),
    .mem_addr_o(mem_addr),
    .mem_wdat_o(mem_wdat),
    .mem_be_o  (mem_be),
    .done_o    (wp_done)
  );

  assign LDR_ACK = ack_q;
  assign busy    = (state_q != IDLE) || hold_v_q;

`ifdef LDR_SDRAM_SINK_CKSUM_EN
  assign cksum       = cksum_q;
  assign cksum_valid = cksum_valid_q;
`endif

endmodule
